// File: rtl/mvb_pkg.sv
// Shared types and frame-length helpers for the MVB receive sequencer.
package mvb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMData,
    StMEnd,
    StWaitReply,
    StSData,
    StSEnd
  } state_e;

  typedef enum logic [2:0] {
    ErrNone    = 3'd0,
    ErrDelim   = 3'd1,
    ErrLen     = 3'd2,
    ErrEndTo   = 3'd3,
    ErrReplyTo = 3'd4,
    ErrUnexp   = 3'd5,
    ErrFcode   = 3'd6
  } err_e;

  localparam int unsigned M_TOTAL_BITS = 24;
  localparam int unsigned M_HDR_BITS   = 16;

  // Slave frame length: 16<<fcode data bits plus 8 check bits per 64 data bits (min 8).
  function automatic int unsigned slave_bits(input logic [3:0] fcode);
    int unsigned data_bits;
    int unsigned chk_bits;
    if (fcode > 4'd4) begin
      return 32'd24;
    end
    data_bits = 32'd16 << fcode;
    chk_bits  = (data_bits / 32'd64) * 32'd8;
    if (chk_bits < 32'd8) begin
      chk_bits = 32'd8;
    end
    return data_bits + chk_bits;
  endfunction

  function automatic logic is_reserved(input logic [3:0] fcode);
    return (fcode >= 4'd5) && (fcode <= 4'd7);
  endfunction

endpackage

// File: rtl/mvb_timeout_timer.sv
// Cycle timer: cleared while idle, counts while enabled, pulses on the last allowed cycle.
module mvb_timeout_timer #(
  parameter int unsigned Width = 9
) (
  input  logic             clk_6M,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             expire
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_6M or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && !clear && (cnt_q == limit - 1'b1);

endmodule

// File: rtl/mvb_frame_rx_ctrl.sv
// MVB receive sequencer: tracks master/slave frame boundaries, captures F_code/address,
// requests end-delimiter evaluation and flags delimiter, length and timeout errors.
module mvb_frame_rx_ctrl
  import mvb_pkg::*;
#(
  parameter int unsigned REPLY_TIMEOUT = 256,
  parameter int unsigned END_WAIT      = 8,
  parameter int unsigned CNT_W         = 9
) (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        M_frame,
  input  logic        S_frame,
  input  logic        E_frame,
  input  logic        E_delimit,
  input  logic        E_length,
  input  logic        bit_valid,
  input  logic        bit_data,
  output logic        frame_end,
  output logic        shift_en,
  output logic        in_slave,
  output logic [3:0]  fcode,
  output logic [11:0] addr,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic        reply_to
);

  localparam int unsigned TmrMax = (REPLY_TIMEOUT > END_WAIT) ? REPLY_TIMEOUT : END_WAIT;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  state_e           st_q, st_d;
  logic             m_frame_q, s_frame_q;
  logic             m_start, s_start;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_inc, slave_len;
  logic [15:0]      hdr_q, hdr_d;
  logic [3:0]       fcode_q, fcode_d;
  logic [11:0]      addr_q, addr_d;
  logic             done_q, done_d, err_q, err_d, rto_q, rto_d;
  err_e             code_q, code_d;
  logic             in_end, in_wait, end_exp, reply_exp;

  assign m_start     = M_frame & ~m_frame_q;
  assign s_start     = S_frame & ~s_frame_q;
  assign bit_cnt_inc = bit_cnt_q + 1'b1;
  assign slave_len   = CNT_W'(slave_bits(fcode_q));
  assign in_end      = (st_q == StMEnd) || (st_q == StSEnd);
  assign in_wait     = (st_q == StWaitReply);

  mvb_timeout_timer #(.Width(TmrW)) u_end_timer (
    .clk_6M (clk_6M),
    .rst    (rst),
    .clear  (!in_end),
    .enable (in_end),
    .limit  (TmrW'(END_WAIT)),
    .expire (end_exp)
  );

  mvb_timeout_timer #(.Width(TmrW)) u_reply_timer (
    .clk_6M (clk_6M),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .limit  (TmrW'(REPLY_TIMEOUT)),
    .expire (reply_exp)
  );

  always_comb begin
    st_d      = st_q;
    bit_cnt_d = bit_cnt_q;
    hdr_d     = hdr_q;
    fcode_d   = fcode_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rto_d     = 1'b0;
    code_d    = ErrNone;

    if (E_delimit) begin
      st_d   = StIdle;
      err_d  = 1'b1;
      code_d = ErrDelim;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (m_start) begin
            st_d      = StMData;
            bit_cnt_d = '0;
          end else if (s_start) begin
            err_d  = 1'b1;
            code_d = ErrUnexp;
          end
        end
        StMData: begin
          if (m_start) begin
            err_d  = 1'b1;
            code_d = ErrUnexp;
          end else if (bit_valid) begin
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_q < CNT_W'(M_HDR_BITS)) begin
              hdr_d = {hdr_q[14:0], bit_data};
            end
            if (bit_cnt_inc == CNT_W'(M_TOTAL_BITS)) begin
              st_d = StMEnd;
            end
          end
        end
        StMEnd, StSEnd: begin
          if (E_length) begin
            st_d   = StIdle;
            err_d  = 1'b1;
            code_d = ErrLen;
          end else if (E_frame) begin
            done_d = 1'b1;
            st_d   = StIdle;
            if (st_q == StMEnd) begin
              fcode_d = hdr_q[15:12];
              addr_d  = hdr_q[11:0];
              if (is_reserved(hdr_q[15:12])) begin
                err_d  = 1'b1;
                code_d = ErrFcode;
              end else begin
                st_d = StWaitReply;
              end
            end
          end else if (end_exp) begin
            st_d   = StIdle;
            err_d  = 1'b1;
            code_d = ErrEndTo;
          end
        end
        StWaitReply: begin
          if (reply_exp) begin
            st_d   = StIdle;
            err_d  = 1'b1;
            rto_d  = 1'b1;
            code_d = ErrReplyTo;
          end else if (s_start) begin
            st_d      = StSData;
            bit_cnt_d = '0;
          end else if (m_start) begin
            err_d  = 1'b1;
            code_d = ErrUnexp;
          end
        end
        StSData: begin
          if (m_start) begin
            err_d  = 1'b1;
            code_d = ErrUnexp;
          end else if (bit_valid) begin
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_inc == slave_len) begin
              st_d = StSEnd;
            end
          end
        end
        default: st_d = StIdle;
      endcase
    end

    // A new master start always wins the next state, even when an error is flagged.
    if (err_d && m_start) begin
      st_d      = StMData;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_6M or negedge rst) begin
    if (!rst) begin
      st_q      <= StIdle;
      m_frame_q <= 1'b0;
      s_frame_q <= 1'b0;
      bit_cnt_q <= '0;
      hdr_q     <= '0;
      fcode_q   <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rto_q     <= 1'b0;
      code_q    <= ErrNone;
    end else begin
      st_q      <= st_d;
      m_frame_q <= M_frame;
      s_frame_q <= S_frame;
      bit_cnt_q <= bit_cnt_d;
      hdr_q     <= hdr_d;
      fcode_q   <= fcode_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rto_q     <= rto_d;
      if (err_d) begin
        code_q <= code_d;
      end
    end
  end

  assign frame_end  = in_end;
  assign in_slave   = (st_q == StSData) || (st_q == StSEnd);
  assign shift_en   = bit_valid && ((st_q == StMData) || (st_q == StSData));
  assign fcode      = fcode_q;
  assign addr       = addr_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;
  assign reply_to   = rto_q;

endmodule

// File: tb/tb_mvb_frame_rx_ctrl.sv
// Randomised transaction bench for mvb_frame_rx_ctrl with a frame-level reference model.
module tb_mvb_frame_rx_ctrl;

  localparam int unsigned REPLY_TIMEOUT = 256;
  localparam int unsigned END_WAIT      = 8;

  logic        clk_6M = 1'b0;
  logic        rst;
  logic        M_frame, S_frame, E_frame, E_delimit, E_length, bit_valid, bit_data;
  logic        frame_end, shift_en, in_slave, frame_done, frame_err, reply_to;
  logic [3:0]  fcode;
  logic [11:0] addr;
  logic [2:0]  err_code;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_shift = 0, n_done = 0, n_err = 0, n_rto = 0;
  logic [3:0]  exp_f = '0;
  logic [11:0] exp_a = '0;

  mvb_frame_rx_ctrl #(
    .REPLY_TIMEOUT (REPLY_TIMEOUT),
    .END_WAIT      (END_WAIT),
    .CNT_W         (9)
  ) dut (
    .clk_6M     (clk_6M),
    .rst        (rst),
    .M_frame    (M_frame),
    .S_frame    (S_frame),
    .E_frame    (E_frame),
    .E_delimit  (E_delimit),
    .E_length   (E_length),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .frame_end  (frame_end),
    .shift_en   (shift_en),
    .in_slave   (in_slave),
    .fcode      (fcode),
    .addr       (addr),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .reply_to   (reply_to)
  );

  always #5 clk_6M = ~clk_6M;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Frame length from the bus rules: 16<<f data bits, 8 check bits per 64 data (min 8).
  function automatic int model_len(input int f);
    int data_bits, chk_bits;
    if (f >= 5) return 24;
    data_bits = 16 * (1 << f);
    chk_bits  = (data_bits / 64) * 8;
    if (chk_bits < 8) chk_bits = 8;
    return data_bits + chk_bits;
  endfunction

  function automatic bit model_reserved(input int f);
    return (f >= 5) && (f <= 7);
  endfunction

  // One clock: sample shift_en with inputs applied, then the registered pulses after the edge.
  task automatic cycle();
    #1;
    if (shift_en) n_shift++;
    @(posedge clk_6M);
    #1;
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (reply_to) n_rto++;
  endtask

  task automatic send_bits(input int n, input logic [15:0] hdr, input int gap_max);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(gap_max, 0)) cycle();
      if (i == n - 1) check_val("fe_early", frame_end, 0);
      bit_valid = 1'b1;
      bit_data  = (i < 16) ? hdr[15-i] : 1'($urandom);
      cycle();
      bit_valid = 1'b0;
      bit_data  = 1'b0;
    end
  endtask

  task automatic do_master(input logic [3:0] f, input logic [11:0] a, input int mo,
                           input bit started);
    int e0;
    if (!started) begin
      M_frame = 1'b1;
      cycle();
      M_frame = 1'b0;
    end
    send_bits(24, {f, a}, 2);
    check_val("m_frame_end", frame_end, 1);
    e0 = n_err;
    if (mo == 0) begin
      repeat ($urandom_range(END_WAIT - 1, 0)) cycle();
      E_frame = 1'b1;
      cycle();
      E_frame = 1'b0;
      exp_f = f;
      exp_a = a;
      check_val("m_done", frame_done, 1);
      check_val("m_fcode", fcode, exp_f);
      check_val("m_addr", addr, exp_a);
      check_val("m_err_cnt", n_err - e0, model_reserved(f) ? 1 : 0);
      if (model_reserved(f)) check_val("m_fcode_err", err_code, 6);
      check_val("m_fe_drop", frame_end, 0);
    end else if (mo == 1) begin
      repeat ($urandom_range(END_WAIT - 1, 0)) cycle();
      E_length = 1'b1;
      cycle();
      E_length = 1'b0;
      check_val("m_len_err", frame_err, 1);
      check_val("m_len_code", err_code, 2);
      check_val("m_len_done", frame_done, 0);
      check_val("m_len_fcode", fcode, exp_f);
      check_val("m_len_addr", addr, exp_a);
    end else begin
      repeat (END_WAIT - 1) cycle();
      check_val("end_to_early", n_err - e0, 0);
      cycle();
      check_val("end_to_err", frame_err, 1);
      check_val("end_to_code", err_code, 3);
      check_val("end_to_fe", frame_end, 0);
    end
  endtask

  // Starts in WAIT_REPLY. so: 0/3 good, 1 bad end delimiter, 2 master start mid-frame.
  task automatic do_slave(input logic [3:0] f, input int so);
    int len, s0, e0, k;
    len = model_len(int'(f));
    repeat ($urandom_range(20, 0)) cycle();
    e0 = n_err;
    s0 = n_shift;
    S_frame = 1'b1;
    cycle();
    S_frame = 1'b0;
    check_val("s_in_slave", in_slave, 1);
    if (so == 2) begin
      k = $urandom_range(len - 1, 1);
      send_bits(k, 16'($urandom), 2);
      M_frame = 1'b1;
      cycle();
      M_frame = 1'b0;
      check_val("s_mid_err", frame_err, 1);
      check_val("s_mid_code", err_code, 5);
      check_val("s_mid_slave", in_slave, 0);
      check_val("s_mid_shift", n_shift - s0, k);
    end else begin
      send_bits(len, 16'($urandom), 2);
      check_val("s_frame_end", frame_end, 1);
      check_val("s_shift_cnt", n_shift - s0, len);
      check_val("s_no_err", n_err - e0, 0);
      if (so == 1) begin
        E_length = 1'b1;
        cycle();
        E_length = 1'b0;
        check_val("s_len_err", frame_err, 1);
        check_val("s_len_code", err_code, 2);
      end else begin
        E_frame = 1'b1;
        cycle();
        E_frame = 1'b0;
        check_val("s_done", frame_done, 1);
        check_val("s_err", frame_err, 0);
        check_val("s_slave_drop", in_slave, 0);
        check_val("s_fe_drop", frame_end, 0);
      end
    end
  endtask

  task automatic run_txn(input logic [3:0] f, input logic [11:0] a, input int mo,
                         input bit started);
    bit         again;
    bit         st;
    int         mo_i, so;
    logic [3:0] ff;
    logic [11:0] aa;
    st   = started;
    ff   = f;
    aa   = a;
    mo_i = mo;
    do begin
      again = 1'b0;
      do_master(ff, aa, mo_i, st);
      if (mo_i == 0 && !model_reserved(int'(ff))) begin
        so = $urandom_range(3, 0);
        do_slave(ff, so);
        if (so == 2) begin
          again = 1'b1;
          st    = 1'b1;
          ff    = 4'($urandom);
          aa    = 12'($urandom);
          mo_i  = 0;
        end
      end
    end while (again);
  endtask

  initial begin
    int r0, r;
    rst = 1'b0;
    {M_frame, S_frame, E_frame, E_delimit, E_length, bit_valid, bit_data} = '0;
    repeat (3) @(posedge clk_6M);
    #1;
    check_val("rst_frame_end", frame_end, 0);
    check_val("rst_in_slave", in_slave, 0);
    check_val("rst_fcode", fcode, 0);
    check_val("rst_addr", addr, 0);
    check_val("rst_done", frame_done, 0);
    check_val("rst_err", frame_err, 0);
    check_val("rst_code", err_code, 0);
    check_val("rst_rto", reply_to, 0);
    rst = 1'b1;
    cycle();

    // Good master F_code=2 then a 72-bit slave reply.
    do_master(4'd2, 12'h3A5, 0, 1'b0);
    do_slave(4'd2, 0);

    // Master F_code=1 with no reply: timeout on the REPLY_TIMEOUT-th cycle.
    do_master(4'd1, 12'h0F0, 0, 1'b0);
    r0 = n_rto;
    repeat (REPLY_TIMEOUT - 1) cycle();
    check_val("rto_early", n_rto - r0, 0);
    cycle();
    check_val("rto_pulse", reply_to, 1);
    check_val("rto_err", frame_err, 1);
    check_val("rto_code", err_code, 4);
    S_frame = 1'b1;
    cycle();
    S_frame = 1'b0;
    check_val("idle_unexp_err", frame_err, 1);
    check_val("idle_unexp_code", err_code, 5);

    // Bad end delimiter keeps the previous good F_code/address.
    do_master(4'd0, 12'h123, 1, 1'b0);

    // Bad start delimiter mid slave frame together with a master start.
    do_master(4'd3, 12'hABC, 0, 1'b0);
    S_frame = 1'b1;
    cycle();
    S_frame = 1'b0;
    send_bits(50, 16'h0, 1);
    E_delimit = 1'b1;
    M_frame   = 1'b1;
    cycle();
    E_delimit = 1'b0;
    M_frame   = 1'b0;
    check_val("delim_err", frame_err, 1);
    check_val("delim_code", err_code, 1);
    check_val("delim_slave", in_slave, 0);
    check_val("delim_fe", frame_end, 0);
    run_txn(4'($urandom), 12'($urandom), 0, 1'b1);

    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(5, 0);
      run_txn(4'($urandom), 12'($urandom), (r == 0) ? 1 : ((r == 1) ? 2 : 0), 1'b0);
    end

    // Asynchronous reset in the middle of a slave frame.
    do_master(4'd2, 12'h5A5, 0, 1'b0);
    S_frame = 1'b1;
    cycle();
    S_frame = 1'b0;
    send_bits(30, 16'hFFFF, 1);
    bit_valid = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check_val("arst_shift_en", shift_en, 0);
    check_val("arst_frame_end", frame_end, 0);
    check_val("arst_in_slave", in_slave, 0);
    check_val("arst_fcode", fcode, 0);
    check_val("arst_addr", addr, 0);
    check_val("arst_err", frame_err, 0);
    check_val("arst_code", err_code, 0);
    bit_valid = 1'b0;
    @(posedge clk_6M);
    #1;
    rst = 1'b1;
    cycle();
    S_frame = 1'b1;
    cycle();
    S_frame = 1'b0;
    check_val("post_rst_err", frame_err, 1);
    check_val("post_rst_code", err_code, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
